lot_digit_entry: RTL and testbench

- Front-end input stage for the lottery checker.
- Turns raw switch/button inputs into the checker's strobe protocol: one validated BCD digit per `insere` pulse, a `fim` pulse after the fifth digit, and a `fim_jogo` pulse to start a new round.
- Sits directly upstream of the checker. Its outputs drive the checker's `num`/`insere`/`fim`/`fim_jogo` inputs one-to-one.

---
 rtl/lot_pkg.sv | 17 +
 rtl/lot_digit_entry_if.sv | 25 ++
 rtl/lot_debounce.sv | 56 +++++
 rtl/lot_digit_entry.sv | 146 ++++++++++++++
 tb/tb_lot_digit_entry.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/lot_pkg.sv
// Shared types and constants for the lottery entry front-end.
// Optional echo shift register is enabled by LOT_ENTRY_ECHO_EN.
package lot_pkg;

  localparam int DIGIT_W = 4;
  localparam int ECHO_W = 20;
  localparam int N_DIGITS_DEF = 5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    COLLECT,
    FINISH,
    DONE,
    NEWG
  } state_t;

endpackage

// File: rtl/lot_digit_entry_if.sv
// Strobe/status bundle from the entry stage to the checker and display.
// Master drives, slave observes.
interface lot_digit_entry_if;
  import lot_pkg::*;

  logic [DIGIT_W-1:0] num;
  logic               insere;
  logic               fim;
  logic               fim_jogo;
  logic [2:0]         digit_idx;
  logic               err;
  logic               done;
  logic [ECHO_W-1:0]  echo;

  modport master (
    output num, insere, fim, fim_jogo,
    output digit_idx, err, done, echo
  );

  modport slave (
    input num, insere, fim, fim_jogo,
    input digit_idx, err, done, echo
  );

endinterface

// File: rtl/lot_debounce.sv
// Button conditioner: 2-FF sync, saturating debounce counter,
// registered rising-edge pulse.
module lot_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples that disagree with level_q
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CMAX) begin
      level_d = s2_q;
      rise_d  = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/lot_digit_entry.sv
// Digit entry stage: buttons/switches -> checker strobe protocol.
// Define LOT_ENTRY_ECHO_EN to build the ticket echo register.
module lot_digit_entry
  import lot_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int N_DIGITS   = N_DIGITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] sw,
  input  logic               btn_enter,
  input  logic               btn_new,
  lot_digit_entry_if.master  eif
);

  logic [DIGIT_W-1:0] sw_s1_q, sw_s2_q;
  logic lvl_enter, rise_enter;
  logic lvl_new, rise_new;
  logic p_enter, p_new;

  state_t state_q, state_d;
  logic [DIGIT_W-1:0] num_q, num_d;
  logic [2:0] idx_q, idx_d;
  logic insere_q, insere_d;
  logic fim_q, fim_d;
  logic fj_q, fj_d;
  logic err_q, err_d;
  logic done_q, done_d;

  lot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_enter),
    .level (lvl_enter),
    .rise  (rise_enter)
  );

  lot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_new (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_new),
    .level (lvl_new),
    .rise  (rise_new)
  );

  assign p_enter = rise_enter & lvl_enter;
  assign p_new   = rise_new & lvl_new;

  // p_new is tested first so a simultaneous enter is dropped
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    idx_d    = idx_q;
    done_d   = done_q;
    insere_d = 1'b0;
    fim_d    = 1'b0;
    fj_d     = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (p_new) begin
          state_d = NEWG;
        end else if (p_enter) begin
          if (sw_s2_q <= DIGIT_MAX) begin
            num_d    = sw_s2_q;
            insere_d = 1'b1;
            idx_d    = idx_q + 3'd1;
            if (idx_q == 3'(N_DIGITS - 1))
              state_d = FINISH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FINISH: begin
        fim_d   = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (p_new)
          state_d = NEWG;
      end
      NEWG: begin
        fj_d    = 1'b1;
        idx_d   = 3'd0;
        done_d  = 1'b0;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      state_q  <= COLLECT;
      num_q    <= '0;
      idx_q    <= 3'd0;
      insere_q <= 1'b0;
      fim_q    <= 1'b0;
      fj_q     <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      state_q  <= state_d;
      num_q    <= num_d;
      idx_q    <= idx_d;
      insere_q <= insere_d;
      fim_q    <= fim_d;
      fj_q     <= fj_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

`ifdef LOT_ENTRY_ECHO_EN
  logic [ECHO_W-1:0] echo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      echo_q <= '0;
    else if (state_q == NEWG)
      echo_q <= '0;
    else if (insere_d)
      echo_q <= {echo_q[ECHO_W-DIGIT_W-1:0], num_d};
  end

  assign eif.echo = echo_q;
`else
  assign eif.echo = '0;
`endif

  assign eif.num       = num_q;
  assign eif.insere    = insere_q;
  assign eif.fim       = fim_q;
  assign eif.fim_jogo  = fj_q;
  assign eif.digit_idx = idx_q;
  assign eif.err       = err_q;
  assign eif.done      = done_q;

endmodule

// File: tb/tb_lot_digit_entry.sv
// Directed bench for lot_digit_entry with DEB_CYCLES=4.
// Echo expectations follow LOT_ENTRY_ECHO_EN.
module tb_lot_digit_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       btn_enter;
  logic       btn_new;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_ins = 0, n_fim = 0, n_fj = 0, n_err = 0, n_excl = 0;
  int ins_cyc = 0, fim_cyc = 0;
  logic [3:0] last_num = '0;
  int b_ins, b_fim, b_fj, b_err;

  lot_digit_entry_if eif ();

  lot_digit_entry #(.DEB_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_new   (btn_new),
    .eif       (eif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eif.insere) begin
      n_ins++;
      ins_cyc = cyc;
      last_num = eif.num;
    end
    if (eif.fim) begin
      n_fim++;
      fim_cyc = cyc;
    end
    if (eif.fim_jogo) n_fj++;
    if (eif.err) n_err++;
    if (32'(eif.insere) + 32'(eif.fim) + 32'(eif.fim_jogo) > 1)
      n_excl++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] outs();
    return {eif.num, eif.insere, eif.fim, eif.fim_jogo,
            eif.digit_idx, eif.err, eif.done, eif.echo[11:0]};
  endfunction

  task automatic snap();
    b_ins = n_ins; b_fim = n_fim; b_fj = n_fj; b_err = n_err;
  endtask

  task automatic press(input logic en, input logic nw);
    repeat (3) @(negedge clk);
    btn_enter = en;
    btn_new = nw;
    repeat (12) @(negedge clk);
    btn_enter = 1'b0;
    btn_new = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic digit(input logic [3:0] d);
    sw = d;
    press(1'b1, 1'b0);
  endtask

  logic [3:0] seq [5] = '{4'd4, 4'd7, 4'd0, 4'd1, 4'd9};
  logic [19:0] echo_exp;

  initial begin
    reset = 1'b1;
    sw = '0;
    btn_enter = 1'b0;
    btn_new = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_held", outs(), 32'd0);
    chk("rst_echo", 32'(eif.echo), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_after", outs(), 32'd0);

    // full ticket 4,7,0,1,9
    snap();
    for (int i = 0; i < 5; i++) begin
      digit(seq[i]);
      chk("t_num", 32'(last_num), 32'(seq[i]));
      chk("t_idx", 32'(eif.digit_idx), 32'(i + 1));
      chk("t_ins", 32'(n_ins - b_ins), 32'(i + 1));
    end
    chk("t_fim_cnt", 32'(n_fim - b_fim), 32'd1);
    chk("t_fim_lat", 32'(fim_cyc - ins_cyc), 32'd1);
    chk("t_done", 32'(eif.done), 32'd1);
`ifdef LOT_ENTRY_ECHO_EN
    echo_exp = 20'h47019;
`else
    echo_exp = 20'h0;
`endif
    chk("t_echo", 32'(eif.echo), 32'(echo_exp));

    // DONE ignores enter, new starts a game
    snap();
    digit(4'd3);
    chk("d_noins", 32'(n_ins - b_ins), 32'd0);
    chk("d_done", 32'(eif.done), 32'd1);
    chk("d_idx", 32'(eif.digit_idx), 32'd5);
    press(1'b0, 1'b1);
    chk("d_fj", 32'(n_fj - b_fj), 32'd1);
    chk("d_idx0", 32'(eif.digit_idx), 32'd0);
    chk("d_done0", 32'(eif.done), 32'd0);
    chk("d_echo0", 32'(eif.echo), 32'd0);

    // rejected digit then a valid one
    snap();
    digit(4'd12);
    chk("e_err", 32'(n_err - b_err), 32'd1);
    chk("e_noins", 32'(n_ins - b_ins), 32'd0);
    chk("e_idx", 32'(eif.digit_idx), 32'd0);
    digit(4'd3);
    chk("e_ins", 32'(n_ins - b_ins), 32'd1);
    chk("e_num", 32'(last_num), 32'd3);
    chk("e_idx1", 32'(eif.digit_idx), 32'd1);
    chk("e_numhold", 32'(eif.num), 32'd3);

    // bouncy enter: 2 high / 1 low x4, then stable high
    snap();
    sw = 4'd5;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      btn_enter = 1'b1;
      repeat (2) @(negedge clk);
      btn_enter = 1'b0;
      @(negedge clk);
    end
    btn_enter = 1'b1;
    repeat (15) @(negedge clk);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    chk("b_ins", 32'(n_ins - b_ins), 32'd1);
    chk("b_num", 32'(last_num), 32'd5);
    chk("b_idx", 32'(eif.digit_idx), 32'd2);

    // abort after 2 digits
    snap();
    press(1'b0, 1'b1);
    chk("a_fj", 32'(n_fj - b_fj), 32'd1);
    chk("a_nofim", 32'(n_fim - b_fim), 32'd0);
    chk("a_idx", 32'(eif.digit_idx), 32'd0);

    // simultaneous enter/new mid-ticket
    digit(4'd6);
    snap();
    sw = 4'd8;
    press(1'b1, 1'b1);
    chk("s_fj", 32'(n_fj - b_fj), 32'd1);
    chk("s_noins", 32'(n_ins - b_ins), 32'd0);
    chk("s_idx", 32'(eif.digit_idx), 32'd0);

    // reset during the third press
    digit(4'd2);
    digit(4'd5);
    chk("r_idx2", 32'(eif.digit_idx), 32'd2);
    snap();
    sw = 4'd6;
    repeat (3) @(negedge clk);
    btn_enter = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("r_held", outs(), 32'd0);
    btn_enter = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("r_noins", 32'(n_ins - b_ins), 32'd0);
    chk("r_out", outs(), 32'd0);

    chk("excl", 32'(n_excl), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
